// File: rtl/multi_radix_if.sv
// Operand/result handshake bundle for multi_radix.
// The producer and consumer side use the master modport; the multiplier uses slave.
interface multi_radix_if #(
    parameter int DATA_WIDTH = 2048
);
    logic [DATA_WIDTH-1:0]   dat1;
    logic [DATA_WIDTH-1:0]   dat2;
    logic                    vld_in;
    logic                    rdy_in;
    logic                    abort;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    vld_out;
    logic                    rdy_out;

    modport master (
        output dat1, dat2, vld_in, abort, rdy_out,
        input  rdy_in, product, vld_out
    );

    modport slave (
        input  dat1, dat2, vld_in, abort, rdy_out,
        output rdy_in, product, vld_out
    );
endinterface

// File: rtl/multi_radix.sv
// Sequential multiplier retiring DIGIT_WIDTH multiplier bits per cycle, valid/ready on both sides.
// Define MULTI_RADIX_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module multi_radix #(
    parameter int DATA_WIDTH  = 2048,
    parameter int DIGIT_WIDTH = 4
) (
    input logic          clk,
    input logic          rst,
    multi_radix_if.slave bus
);
    localparam int N  = DATA_WIDTH / DIGIT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = DATA_WIDTH + DIGIT_WIDTH;
    localparam int AW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [AW-1:0]         prod_q, prod_d;
    logic                  vld_q, vld_d;

    logic [PW-1:0]         pp;
    logic [PW-1:0]         sum;
    logic [AW-1:0]         full;
    logic                  rdy_in;
    logic                  accept;

`ifdef MULTI_RADIX_SIGNED_EN
    logic sign_q, sign_d;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [AW-1:0] apply_sign(input logic [AW-1:0] m, input logic neg);
        return neg ? -m : m;
    endfunction
`endif

    // The 2*DATA_WIDTH accumulator is {acc_q, mplier_q}: instead of shifting each partial
    // product left, the accumulator shifts right and finished low bits fill the vacated
    // top of the multiplier register. Only a DATA_WIDTH+DIGIT_WIDTH adder is needed.
    assign pp   = PW'(mcand_q) * PW'(mplier_q[DIGIT_WIDTH-1:0]);
    assign sum  = PW'(acc_q) + pp;
    assign full = {sum, mplier_q[DATA_WIDTH-1:DIGIT_WIDTH]};

    assign rdy_in = (state_q == IDLE) || ((state_q == DONE) && bus.rdy_out);
    assign accept = bus.vld_in && rdy_in && !bus.abort;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        vld_d    = vld_q;
`ifdef MULTI_RADIX_SIGNED_EN
        sign_d   = sign_q;
`endif

        if (accept) begin
            state_d = BUSY;
            cnt_d   = '0;
            acc_d   = '0;
`ifdef MULTI_RADIX_SIGNED_EN
            mcand_d  = magnitude(bus.dat1);
            mplier_d = magnitude(bus.dat2);
            sign_d   = bus.dat1[DATA_WIDTH-1] ^ bus.dat2[DATA_WIDTH-1];
`else
            mcand_d  = bus.dat1;
            mplier_d = bus.dat2;
`endif
        end

        case (state_q)
            BUSY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = sum[PW-1:DIGIT_WIDTH];
                    mplier_d = {sum[DIGIT_WIDTH-1:0], mplier_q[DATA_WIDTH-1:DIGIT_WIDTH]};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
`ifdef MULTI_RADIX_SIGNED_EN
                        prod_d = apply_sign(full, sign_q);
`else
                        prod_d = full;
`endif
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.abort) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end else if (bus.rdy_out) begin
                    vld_d = 1'b0;
                    if (!accept) state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            vld_q    <= 1'b0;
`ifdef MULTI_RADIX_SIGNED_EN
            sign_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            vld_q    <= vld_d;
`ifdef MULTI_RADIX_SIGNED_EN
            sign_q   <= sign_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
    end

    assign bus.rdy_in  = rdy_in;
    assign bus.product = prod_q;
    assign bus.vld_out = vld_q;
endmodule

// File: tb/tb_multi_radix.sv
// Bench for multi_radix: 16-bit vectors and handshake/abort/reset sequences, random
// backpressured traffic against a queue model, and random 2048-bit products per digit width.
module tb_multi_radix;
    localparam int W0 = 16;
    localparam int WW = 2048;

    typedef logic [2*WW-1:0] wide_t;
    typedef struct {
        logic [W0-1:0]   a;
        logic [W0-1:0]   b;
        logic [2*W0-1:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_w = 1'b1;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   wide_done = 0;

    always #5 clk = ~clk;

    multi_radix_if #(.DATA_WIDTH(W0)) b0 ();
    multi_radix #(.DATA_WIDTH(W0), .DIGIT_WIDTH(4)) u0 (.clk(clk), .rst(rst), .bus(b0));

    function automatic logic [2*W0-1:0] ref16(input logic [W0-1:0] a, input logic [W0-1:0] b);
`ifdef MULTI_RADIX_SIGNED_EN
        return {{W0{a[W0-1]}}, a} * {{W0{b[W0-1]}}, b};
`else
        return {{W0{1'b0}}, a} * {{W0{1'b0}}, b};
`endif
    endfunction

    function automatic wide_t refw(input logic [WW-1:0] a, input logic [WW-1:0] b);
`ifdef MULTI_RADIX_SIGNED_EN
        return {{WW{a[WW-1]}}, a} * {{WW{b[WW-1]}}, b};
`else
        return {{WW{1'b0}}, a} * {{WW{1'b0}}, b};
`endif
    endfunction

    function automatic logic [63:0] fold64(input wide_t v);
        logic [63:0] f = '0;
        for (int i = 0; i < 2*WW/64; i++) f ^= v[i*64 +: 64];
        return f;
    endfunction

    task automatic check(input string name, input wide_t got, input wide_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h (fold %0h) required %0h (fold %0h)",
                     name, got[63:0], fold64(got), exp[63:0], fold64(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_vld(output int cyc);
        cyc = 0;
        while (!b0.vld_out && cyc < 12) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input logic [W0-1:0] a, input logic [W0-1:0] b, input logic [2*W0-1:0] exp);
        int   cyc = 0;
        logic busy_rdy = 1'b0;
        b0.dat1 = a; b0.dat2 = b; b0.vld_in = 1'b1; b0.rdy_out = 1'b1;
        tick();
        b0.vld_in = 1'b0;
        while (!b0.vld_out && cyc < 12) begin
            busy_rdy |= b0.rdy_in;
            tick();
            cyc++;
        end
        check("vec_latency", wide_t'(cyc), wide_t'(4));
        check("vec_busy_rdy_in", wide_t'(busy_rdy), wide_t'(0));
        check("vec_product", wide_t'(b0.product), wide_t'(exp));
        tick();
        check("vec_vld_pulse", wide_t'(b0.vld_out), wide_t'(0));
    endtask

    task automatic random16(input int n_ops);
        logic [2*W0-1:0] q[$];
        logic [2*W0-1:0] held;
        logic [2*W0-1:0] exp;
        logic            stalled, accepted;
        int sent = 0, recv = 0, cyc = 0;
        b0.vld_in = 1'b0;
        while (recv < n_ops && cyc < n_ops * 40) begin
            if (!b0.vld_in && sent < n_ops && $urandom_range(0, 3) != 0) begin
                b0.dat1 = 16'($urandom); b0.dat2 = 16'($urandom); b0.vld_in = 1'b1;
            end
            b0.rdy_out = ($urandom_range(0, 3) != 0);
            #1;
            if (b0.vld_out && b0.rdy_out) begin
                exp = (q.size() > 0) ? q.pop_front() : '1;
                check("rnd_product", wide_t'(b0.product), wide_t'(exp));
                recv++;
            end
            accepted = b0.vld_in && b0.rdy_in;
            if (accepted) begin
                q.push_back(ref16(b0.dat1, b0.dat2));
                sent++;
            end
            stalled = b0.vld_out && !b0.rdy_out;
            held    = b0.product;
            tick();
            if (accepted) b0.vld_in = 1'b0;
            if (stalled) begin
                check("rnd_stall_vld", wide_t'(b0.vld_out), wide_t'(1));
                check("rnd_stall_prod", wide_t'(b0.product), wide_t'(held));
            end
            cyc++;
        end
        check("rnd_count", wide_t'(recv), wide_t'(n_ops));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_wide
        localparam int G     = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        localparam int N     = WW / G;
        localparam int PAIRS = (g == 0) ? 4 : ((g == 1) ? 16 : 64);

        multi_radix_if #(.DATA_WIDTH(WW)) bw ();
        multi_radix #(.DATA_WIDTH(WW), .DIGIT_WIDTH(G)) dut (.clk(clk), .rst(rst_w), .bus(bw));

        initial begin
            logic [WW-1:0] a, b;
            int cyc;
            bw.dat1 = '0; bw.dat2 = '0; bw.vld_in = 1'b0; bw.abort = 1'b0; bw.rdy_out = 1'b1;
            wait (rst_w == 1'b0);
            tick();
            for (int p = 0; p < PAIRS; p++) begin
                for (int w = 0; w < WW/32; w++) begin
                    a[w*32 +: 32] = $urandom;
                    b[w*32 +: 32] = $urandom;
                end
                if (p == 0) a = '0;
                if (p == 1) begin a = '1; b = '1; end
                bw.dat1 = a; bw.dat2 = b; bw.vld_in = 1'b1;
                tick();
                bw.vld_in = 1'b0;
                cyc = 0;
                while (!bw.vld_out && cyc < N + 4) begin
                    tick();
                    cyc++;
                end
                check("wide_latency", wide_t'(cyc), wide_t'(N));
                check("wide_product", bw.product, refw(a, b));
                tick();
            end
            wide_done++;
        end
    end

    initial begin
        vec_t tbl[8];
        logic [2*W0-1:0] held;
        logic seen;
        int   cyc;

        tbl[0] = '{16'h1234, 16'h5678, 32'h06260060};
        tbl[2] = '{16'h0000, 16'hABCD, 32'h00000000};
        tbl[3] = '{16'h0003, 16'h0005, 32'h0000000F};
        tbl[5] = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[7] = '{16'hABCD, 16'h0000, 32'h00000000};
`ifdef MULTI_RADIX_SIGNED_EN
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        tbl[4] = '{16'hFFFF, 16'h0002, 32'hFFFFFFFE};
        tbl[6] = '{16'h7FFF, 16'h8000, 32'hC0008000};
`else
        tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        tbl[4] = '{16'hFFFF, 16'h0002, 32'h0001FFFE};
        tbl[6] = '{16'h7FFF, 16'h8000, 32'h3FFF8000};
`endif

        b0.dat1 = '0; b0.dat2 = '0; b0.vld_in = 1'b0; b0.abort = 1'b0; b0.rdy_out = 1'b1;
        repeat (2) tick();
        check("rst_rdy_in", wide_t'(b0.rdy_in), wide_t'(1));
        check("rst_vld_out", wide_t'(b0.vld_out), wide_t'(0));
        check("rst_product", wide_t'(b0.product), wide_t'(0));
        rst = 1'b0; rst_w = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(tbl[i].a, tbl[i].b, tbl[i].exp);

        // Backpressure with a second operand pair waiting on vld_in.
        b0.dat1 = 16'h1234; b0.dat2 = 16'h5678; b0.vld_in = 1'b1; b0.rdy_out = 1'b0;
        tick();
        b0.dat1 = 16'h00FF; b0.dat2 = 16'h0100;
        wait_vld(cyc);
        check("bp_latency", wide_t'(cyc), wide_t'(4));
        check("bp_product", wide_t'(b0.product), wide_t'(32'h06260060));
        held = b0.product;
        for (int i = 0; i < 10; i++) begin
            check("bp_rdy_in_low", wide_t'(b0.rdy_in), wide_t'(0));
            tick();
            check("bp_vld_hold", wide_t'(b0.vld_out), wide_t'(1));
            check("bp_prod_hold", wide_t'(b0.product), wide_t'(held));
        end
        b0.rdy_out = 1'b1;
        #1;
        check("bp_rdy_in_release", wide_t'(b0.rdy_in), wide_t'(1));
        tick();
        b0.vld_in = 1'b0;
        check("bp_vld_drop", wide_t'(b0.vld_out), wide_t'(0));
        check("bp_b2b_busy", wide_t'(b0.rdy_in), wide_t'(0));
        wait_vld(cyc);
        check("bp_b2b_latency", wide_t'(cyc), wide_t'(4));
        check("bp_b2b_product", wide_t'(b0.product), wide_t'(32'h0000FF00));
        tick();

        // Abort on the second BUSY cycle.
        b0.dat1 = 16'hFFFF; b0.dat2 = 16'hFFFF; b0.vld_in = 1'b1;
        tick();
        b0.vld_in = 1'b0;
        tick();
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        check("ab_rdy_in", wide_t'(b0.rdy_in), wide_t'(1));
        seen = 1'b0;
        repeat (6) begin seen |= b0.vld_out; tick(); end
        check("ab_no_vld", wide_t'(seen), wide_t'(0));
        check("ab_product_kept", wide_t'(b0.product), wide_t'(32'h0000FF00));
        run_vec(16'h0003, 16'h0005, 32'h0000000F);

        // Abort in IDLE blocks a simultaneous accept.
        b0.dat1 = 16'h1234; b0.dat2 = 16'h5678; b0.vld_in = 1'b1; b0.abort = 1'b1;
        tick();
        b0.vld_in = 1'b0; b0.abort = 1'b0;
        check("idle_abort_no_accept", wide_t'(b0.rdy_in), wide_t'(1));

        // Abort in DONE while the consumer stalls.
        b0.dat1 = 16'h0002; b0.dat2 = 16'h0003; b0.vld_in = 1'b1; b0.rdy_out = 1'b0;
        tick();
        b0.vld_in = 1'b0;
        wait_vld(cyc);
        check("done_ab_product", wide_t'(b0.product), wide_t'(32'h6));
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        check("done_ab_vld", wide_t'(b0.vld_out), wide_t'(0));
        check("done_ab_prod_kept", wide_t'(b0.product), wide_t'(32'h6));
        check("done_ab_rdy_in", wide_t'(b0.rdy_in), wide_t'(1));
        b0.rdy_out = 1'b1;

        // Asynchronous reset between edges mid-BUSY.
        b0.dat1 = 16'h1234; b0.dat2 = 16'h5678; b0.vld_in = 1'b1;
        tick();
        b0.vld_in = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        check("arst_product", wide_t'(b0.product), wide_t'(0));
        check("arst_vld_out", wide_t'(b0.vld_out), wide_t'(0));
        check("arst_rdy_in", wide_t'(b0.rdy_in), wide_t'(1));
        #1 rst = 1'b0;
        tick();
        seen = 1'b0;
        repeat (6) begin seen |= b0.vld_out; tick(); end
        check("arst_no_vld", wide_t'(seen), wide_t'(0));

        random16(150);

        cyc = 0;
        while (wide_done < 3 && cyc < 30000) begin
            tick();
            cyc++;
        end
        check("wide_done", wide_t'(wide_done), wide_t'(3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
